// File: rtl/ycbcr_chroma_modulator.sv
// Composite chroma modulator: NCO-driven quadrature modulation of Cb/Cr onto
// a colour subcarrier, summed with Y and clamped to 8 bits. Latency 3 cycles.
// Optional macro CHROMA_AVG_EN adds a Cb/Cr two-tap averaging stage (latency 4).

package ycbcr_pkg;
    typedef struct packed {
        logic        [7:0] y;
        logic signed [7:0] cb;
        logic signed [7:0] cr;
    } ycbcr_s;
endpackage

module ycbcr_chroma_modulator
    import ycbcr_pkg::*;
#(
    parameter int                PHASE_W      = 24,
    parameter logic [PHASE_W-1:0] PHASE_INIT  = '0,
    parameter int                BURST_AMP    = 32,
    parameter int                BURST_CR     = 0,
    parameter int                BLANK_LEVEL  = 60,
    parameter int                CHROMA_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  ycbcr_s             in,
    input  logic               active,
    input  logic               burst_en,
    input  logic               v_flip,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               phase_reset,
    output logic               out_valid,
    output logic [7:0]         out
);

    localparam logic signed [7:0] BURST_CB_V = 8'(-BURST_AMP);
    localparam logic signed [7:0] BURST_CR_V = 8'(BURST_CR);
    localparam logic        [7:0] BLANK_V    = 8'(BLANK_LEVEL);

    // Quarter-wave table: round(127*sin(2*pi*k/256)) for k = 0..64
    localparam logic [6:0] QSIN [65] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    function automatic logic signed [7:0] sin_lut(input logic [7:0] a);
        logic [6:0] idx;
        logic [7:0] mag;
        idx = a[6] ? 7'(7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        mag = {1'b0, QSIN[idx]};
        return a[7] ? $signed(-mag) : $signed(mag);
    endfunction

    logic [PHASE_W-1:0] acc;
    logic [7:0]         addr;

    assign addr = acc[PHASE_W-1 -: 8];

    // NCO accumulator, free running; phase_reset has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           acc <= '0;
        else if (phase_reset) acc <= PHASE_INIT;
        else                  acc <= acc + phase_inc;
    end

    // Stage-0 view of the sample feeding Stage 1
    logic        [7:0] s0_y;
    logic signed [7:0] s0_cb, s0_cr;
    logic              s0_active, s0_burst, s0_vflip, s0_valid;
    logic        [7:0] s0_addr;

`ifdef CHROMA_AVG_EN
    logic signed [7:0] prev_cb, prev_cr;
    logic signed [8:0] cb_sum, cr_sum;

    assign cb_sum = {prev_cb[7], prev_cb} + {in.cb[7], in.cb};
    assign cr_sum = {prev_cr[7], prev_cr} + {in.cr[7], in.cr};

    // History of the last valid chroma, cleared outside active video
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cb <= '0;
            prev_cr <= '0;
        end else if (!active) begin
            prev_cb <= '0;
            prev_cr <= '0;
        end else if (in_valid) begin
            prev_cb <= in.cb;
            prev_cr <= in.cr;
        end
    end

    // Averaging stage; addr is delayed with the sample to keep phase alignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_y <= '0; s0_cb <= '0; s0_cr <= '0;
            s0_active <= 1'b0; s0_burst <= 1'b0; s0_vflip <= 1'b0;
            s0_valid <= 1'b0; s0_addr <= '0;
        end else begin
            s0_y      <= in.y;
            s0_cb     <= cb_sum[8:1];
            s0_cr     <= cr_sum[8:1];
            s0_active <= active;
            s0_burst  <= burst_en;
            s0_vflip  <= v_flip;
            s0_valid  <= in_valid;
            s0_addr   <= addr;
        end
    end
`else
    assign s0_y      = in.y;
    assign s0_cb     = in.cb;
    assign s0_cr     = in.cr;
    assign s0_active = active;
    assign s0_burst  = burst_en;
    assign s0_vflip  = v_flip;
    assign s0_valid  = in_valid;
    assign s0_addr   = addr;
`endif

    // Stage 1 operand selection and saturating Cr inversion
    logic        [7:0] y_sel;
    logic signed [7:0] cb_sel, cr_sel, cr_fin;

    always_comb begin
        y_sel  = s0_y;
        cb_sel = '0;
        cr_sel = '0;
        if (s0_burst) begin
            y_sel  = BLANK_V;
            cb_sel = BURST_CB_V;
            cr_sel = BURST_CR_V;
        end else if (s0_active) begin
            cb_sel = s0_cb;
            cr_sel = s0_cr;
        end
        cr_fin = cr_sel;
        if (s0_vflip) cr_fin = (cr_sel == 8'sh80) ? 8'sh7f : -cr_sel;
    end

    logic        [7:0] y1;
    logic signed [7:0] cb1, cr1, sin1, cos1;
    logic              v1;

    // Stage 1 register: operands and subcarrier samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1 <= '0; cb1 <= '0; cr1 <= '0; sin1 <= '0; cos1 <= '0; v1 <= 1'b0;
        end else begin
            y1   <= y_sel;
            cb1  <= cb_sel;
            cr1  <= cr_fin;
            sin1 <= sin_lut(s0_addr);
            cos1 <= sin_lut(8'(s0_addr + 8'd64));
            v1   <= s0_valid;
        end
    end

    // Stage 2 arithmetic: floor-shifted quadrature products
    logic signed [15:0] prod_u, prod_v, u_s, v_s, uv_sum;
    logic signed [9:0]  c_next;

    always_comb begin
        prod_u = cb1 * sin1;
        prod_v = cr1 * cos1;
        u_s    = prod_u >>> 7;
        v_s    = prod_v >>> 7;
        uv_sum = u_s + v_s;
        c_next = 10'(uv_sum >>> CHROMA_SHIFT);
    end

    logic        [7:0] y2;
    logic signed [9:0] c2;
    logic              v2;

    // Stage 2 register: chroma term with luma and valid forwarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y2 <= '0; c2 <= '0; v2 <= 1'b0;
        end else begin
            y2 <= y1;
            c2 <= c_next;
            v2 <= v1;
        end
    end

    // Stage 3 arithmetic: luma plus chroma, clamped to 0..255
    logic signed [10:0] yc;
    logic        [7:0]  out_next;

    always_comb begin
        yc = $signed({3'b000, y2}) + $signed({c2[9], c2});
        if (yc < 0)        out_next = 8'd0;
        else if (yc > 255) out_next = 8'd255;
        else               out_next = yc[7:0];
    end

    // Stage 3 register: composite output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= out_next;
            out_valid <= v2;
        end
    end

endmodule

// File: tb/tb_ycbcr_chroma_modulator.sv
// Self-checking bench for ycbcr_chroma_modulator (default build, latency 3).
module tb_ycbcr_chroma_modulator;
    import ycbcr_pkg::*;

    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    ycbcr_s        din = '0;
    logic          active = 1'b0;
    logic          burst_en = 1'b0;
    logic          v_flip = 1'b0;
    logic [PW-1:0] phase_inc = '0;
    logic          phase_reset = 1'b0;
    logic          dout_valid;
    logic [7:0]    dout;

    int n_checks = 0;
    int n_fail   = 0;

    ycbcr_chroma_modulator #(
        .PHASE_W(PW), .PHASE_INIT(24'd0), .BURST_AMP(32), .BURST_CR(0),
        .BLANK_LEVEL(60), .CHROMA_SHIFT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(din),
        .active(active), .burst_en(burst_en), .v_flip(v_flip),
        .phase_inc(phase_inc), .phase_reset(phase_reset),
        .out_valid(dout_valid), .out(dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int sin_ref(input int k);
        real r;
        r = 127.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    typedef struct { bit v; int o; } exp_t;
    exp_t    q[$];
    bit [PW-1:0] acc_m;

    function automatic exp_t model_sample();
        exp_t e;
        int k, s, c, cbe, cre, ye, u, v, ch, o;
        k = int'(acc_m[PW-1 -: 8]);
        s = sin_ref(k);
        c = sin_ref((k + 64) % 256);
        if (burst_en)    begin cbe = -32; cre = 0; ye = 60; end
        else if (active) begin cbe = int'(din.cb); cre = int'(din.cr); ye = int'(din.y); end
        else             begin cbe = 0; cre = 0; ye = int'(din.y); end
        if (v_flip) cre = (cre == -128) ? 127 : -cre;
        u  = (cbe * s) >>> 7;
        v  = (cre * c) >>> 7;
        ch = (u + v) >>> 1;
        o  = ye + ch;
        if (o < 0) o = 0;
        if (o > 255) o = 255;
        e.v = in_valid;
        e.o = o;
        return e;
    endfunction

    initial begin
        exp_t z;
        z.v = 1'b0; z.o = 0;
        acc_m = '0;
        q = '{z, z};
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                acc_m = '0;
                q = '{z, z};
            end else begin
                q.push_back(model_sample());
                if (q.size() > 3) void'(q.pop_front());
                acc_m = phase_reset ? '0 : acc_m + phase_inc;
            end
        end
    end

    // compare process: DUT against the model on every sampled cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && q.size() == 3) begin
                chk("model_valid", int'(dout_valid), int'(q[0].v));
                if (q[0].v) chk("model_out", int'(dout), q[0].o);
            end
        end
    end

    // ---------------- hand-computed literal patterns ----------------
    task automatic run_lit(input string name, input int y, input int cb, input int cr,
                           input bit act, input bit brst, input bit toggle_vf,
                           input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        @(negedge clk);
        din.y = 8'(y); din.cb = 8'(cb); din.cr = 8'(cr);
        active = act; burst_en = brst; v_flip = 1'b0;
        in_valid = 1'b1; phase_inc = 24'h400000; phase_reset = 1'b1;
        @(negedge clk);
        phase_reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (toggle_vf) v_flip = ~v_flip;
            @(negedge clk);
            if (i >= 2) begin
                chk({name, "_valid"}, int'(dout_valid), 1);
                chk(name, int'(dout), e[(i - 2) % 4]);
            end
        end
    endtask

    task automatic run_reset_mid();
        @(negedge clk);
        din.y = 8'd100; din.cb = 8'sd64; din.cr = 8'sd0;
        active = 1'b1; burst_en = 1'b0; v_flip = 1'b0;
        in_valid = 1'b1; phase_inc = 24'h400000; phase_reset = 1'b0;
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_out", int'(dout), 0);
        chk("rst_mid_valid", int'(dout_valid), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 2) chk("rst_lat_valid", int'(dout_valid), 0);
            else begin
                int pat[4];
                pat = '{100, 131, 100, 68};
                chk("rst_seq_valid", int'(dout_valid), 1);
                chk("rst_seq", int'(dout), pat[(i - 2) % 4]);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out", int'(dout), 0);
        chk("reset_valid", int'(dout_valid), 0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_lit("flat",      100,   0,   0, 1'b1, 1'b0, 1'b0, 100, 100, 100, 100);
        run_lit("cb64",      100,  64,   0, 1'b1, 1'b0, 1'b0, 100, 131, 100,  68);
        run_lit("burst",     200,  90, -70, 1'b1, 1'b1, 1'b1,  60,  44,  60,  75);
        run_lit("sat_hi",    250, 127,   0, 1'b1, 1'b0, 1'b0, 250, 255, 250, 186);
        run_lit("sat_lo",      5, 127,   0, 1'b1, 1'b0, 1'b0,   5,  68,   5,   0);
        run_lit("inactive",   16, 100, 100, 1'b0, 1'b0, 1'b0,  16,  16,  16,  16);

        run_reset_mid();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            din.y  = 8'($urandom);
            din.cb = 8'($urandom);
            din.cr = 8'($urandom);
            in_valid    = ($urandom_range(0, 3) != 0);
            active      = $urandom_range(0, 1) == 1;
            burst_en    = ($urandom_range(0, 7) == 0);
            v_flip      = $urandom_range(0, 1) == 1;
            phase_inc   = 24'($urandom);
            phase_reset = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
